// File: rtl/axi_master_bridge_if.sv
// AXI4 master-side bus bundle for axi_master_bridge: AW/W/B/AR/R channels.
// The master modport is the bridge's view; slave is the memory/interconnect view.
interface axi_master_bridge_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [ID_W-1:0]       rid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_master_bridge.sv
// Core request/response to AXI4 master bridge, one outstanding transaction.
// Optional macro AXI_BRIDGE_RESP_CHECK_EN: sticky resp_err on non-OKAY RRESP/BRESP.
module axi_master_bridge #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_ID         = 0
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_wen,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [2:0]                        req_size,
    input  logic [7:0]                        req_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     req_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   req_wstrb,

    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_rdata,
    output logic                              resp_last,
    output logic                              resp_err,

    axi_master_bridge_if.master               m_axi
);
    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]                      size_q;
    logic [7:0]                      len_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]               wstrb_q;
    logic                            aw_done_q;
    logic                            w_done_q;
    logic [7:0]                      beat_cnt_q;

    // Request fields are driven straight from the latches; only the valids are gated by state.
    assign m_axi.awid    = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = 2'b01;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.arid    = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = 2'b01;

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_last     = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.rready  = 1'b0;
        m_axi.bready  = 1'b0;
        // Everything handshake-related stays low while reset is held.
        if (!M_AXI_ARESET) begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) state_d = req_wen ? WADDR : RADDR;
                end
                RADDR: begin
                    m_axi.arvalid = 1'b1;
                    if (m_axi.arready) state_d = RDATA;
                end
                RDATA: begin
                    m_axi.rready = resp_ready;
                    resp_valid   = m_axi.rvalid;
                    resp_rdata   = m_axi.rdata;
                    resp_last    = m_axi.rlast;
                    if (m_axi.rvalid && resp_ready && m_axi.rlast) state_d = IDLE;
                end
                WADDR: begin
                    m_axi.awvalid = !aw_done_q;
                    m_axi.wvalid  = !w_done_q;
                    if ((aw_done_q || m_axi.awready) && (w_done_q || m_axi.wready))
                        state_d = WRESP;
                end
                WRESP: begin
                    m_axi.bready = resp_ready;
                    resp_valid   = m_axi.bvalid;
                    resp_last    = 1'b1;
                    if (m_axi.bvalid && resp_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                len_q   <= req_len;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            // AW and W complete independently; remember each until both are done.
            if (state_q != WADDR || state_d != WADDR) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (m_axi.awvalid && m_axi.awready) aw_done_q <= 1'b1;
                if (m_axi.wvalid && m_axi.wready)   w_done_q  <= 1'b1;
            end
            // Beats past len are still accepted; only RLAST ends the burst.
            if (state_q == RADDR)
                beat_cnt_q <= '0;
            else if (state_q == RDATA && m_axi.rvalid && m_axi.rready)
                beat_cnt_q <= beat_cnt_q + 8'd1;
        end
    end

`ifdef AXI_BRIDGE_RESP_CHECK_EN
    logic err_q;
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET)
            err_q <= 1'b0;
        else if ((m_axi.rvalid && m_axi.rready && m_axi.rresp != 2'b00) ||
                 (m_axi.bvalid && m_axi.bready && m_axi.bresp != 2'b00))
            err_q <= 1'b1;
    end
    assign resp_err = err_q;

    logic unused_sigs;
    assign unused_sigs = ^{m_axi.rid, m_axi.bid, beat_cnt_q};
`else
    assign resp_err = 1'b0;

    logic unused_sigs;
    assign unused_sigs = ^{m_axi.rid, m_axi.bid, m_axi.rresp, m_axi.bresp, beat_cnt_q};
`endif

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge: AXI slave model plus response scoreboard.
module tb_axi_master_bridge;
`ifdef AXI_BRIDGE_RESP_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_len;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_last, resp_err;
    logic [63:0] resp_rdata;

    always #5 clk = ~clk;

    axi_master_bridge_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) m_axi ();

    axi_master_bridge dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_last(resp_last), .resp_err(resp_err),
        .m_axi(m_axi)
    );

    typedef struct { logic [63:0] rdata; logic last; } exp_t;
    exp_t sb[$];

    int n_tot = 0, n_bad = 0, n_resp = 0;
    int cyc = 0, b_cyc = -1, ar_cyc = -1;
    int ar_lat = 0, aw_lat = 0, w_lat = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit rr_toggle = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rpat(input logic [31:0] a, input int i);
        return {16'hC0DE, i[15:0], a};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_req(input bit wen, input logic [31:0] a, input logic [2:0] sz,
                            input logic [7:0] ln, input logic [63:0] wd, input logic [7:0] ws);
        int n;
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_size = sz;
        req_len = ln; req_wdata = wd; req_wstrb = ws;
        if (wen) sb.push_back('{rdata: 64'd0, last: 1'b1});
        else for (int i = 0; i <= int'(ln); i++) sb.push_back('{rdata: rpat(a, i), last: (i == int'(ln))});
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin chk("req_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin tick(); n++; end
        if (sb.size() != 0) begin chk("drain_timeout", 64'(sb.size()), 0); sb.delete(); end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : toggler
        forever begin
            @(posedge clk); #1;
            if (rr_toggle) resp_ready = !resp_ready;
        end
    end

    // Response scoreboard and event recorder, sampled mid-cycle.
    initial begin : mon
        exp_t e;
        bit arv_q = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (sb.size() == 0) chk("sb_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_last", 64'(resp_last), 64'(e.last));
                end
            end
            if (m_axi.bvalid && m_axi.bready) b_cyc = cyc;
            if (m_axi.arvalid && !arv_q) ar_cyc = cyc;
            arv_q = m_axi.arvalid;
        end
    end

    initial begin : slave
        int ar_w = 0, aw_w = 0, w_w = 0, beats = 0, idx = 0;
        bit awd = 0, wd = 0;
        bit s_rst, s_ar, s_aw, s_w, s_r, s_b, s_arv, s_awv, s_wv;
        logic [31:0] a = '0, rbase = '0;
        logic [7:0] len = '0;
        m_axi.arready = 1'b1; m_axi.awready = 1'b1; m_axi.wready = 1'b1;
        m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rlast = 1'b0; m_axi.rresp = '0; m_axi.rid = '0;
        m_axi.bvalid = 1'b0; m_axi.bresp = '0; m_axi.bid = '0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_ar  = m_axi.arvalid && m_axi.arready;
            s_aw  = m_axi.awvalid && m_axi.awready;
            s_w   = m_axi.wvalid && m_axi.wready;
            s_r   = m_axi.rvalid && m_axi.rready;
            s_b   = m_axi.bvalid && m_axi.bready;
            s_arv = m_axi.arvalid; s_awv = m_axi.awvalid; s_wv = m_axi.wvalid;
            if (s_arv) begin a = m_axi.araddr; len = m_axi.arlen; end
            @(posedge clk); #1;
            if (s_rst) begin
                ar_w = 0; aw_w = 0; w_w = 0; beats = 0; idx = 0; awd = 0; wd = 0;
                m_axi.arready = (ar_lat == 0); m_axi.awready = (aw_lat == 0); m_axi.wready = (w_lat == 0);
                m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0; m_axi.bvalid = 1'b0;
                continue;
            end
            if (s_r) idx++;
            if (s_ar) begin ar_w = 0; m_axi.arready = (ar_lat == 0); beats = int'(len) + 1; idx = 0; rbase = a; end
            else if (s_arv) begin ar_w++; m_axi.arready = (ar_w >= ar_lat); end
            else m_axi.arready = (ar_lat == 0);
            if (idx < beats) begin
                m_axi.rvalid = 1'b1; m_axi.rdata = rpat(rbase, idx);
                m_axi.rlast = (idx == beats - 1); m_axi.rresp = rresp_cfg;
            end else begin
                m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
            end
            if (s_aw) begin awd = 1; aw_w = 0; m_axi.awready = (aw_lat == 0); end
            else if (s_awv) begin aw_w++; m_axi.awready = (aw_w >= aw_lat); end
            else m_axi.awready = (aw_lat == 0);
            if (s_w) begin wd = 1; w_w = 0; m_axi.wready = (w_lat == 0); end
            else if (s_wv) begin w_w++; m_axi.wready = (w_w >= w_lat); end
            else m_axi.wready = (w_lat == 0);
            if (s_b) m_axi.bvalid = 1'b0;
            if (awd && wd) begin m_axi.bvalid = 1'b1; m_axi.bresp = bresp_cfg; awd = 0; wd = 0; end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : main
        int nv, wdrop, adrop, n0, r0;
        bit stable;
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
        req_len = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_err", 64'(resp_err), 0);
        chk("rst_arvalid", 64'(m_axi.arvalid), 0);
        chk("rst_awvalid", 64'(m_axi.awvalid), 0);
        chk("rst_wvalid", 64'(m_axi.wvalid), 0);
        chk("rst_rready", 64'(m_axi.rready), 0);
        chk("rst_bready", 64'(m_axi.bready), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 64'(req_ready), 1);
        @(posedge clk); #1;

        // Read, len 3, ARREADY two cycles late
        ar_lat = 2; tick();
        send_req(1'b0, 32'h8000_0000, 3'd3, 8'd3, 64'd0, 8'd0);
        nv = 0; stable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_axi.arvalid) begin
                nv++;
                if (m_axi.araddr !== 32'h8000_0000 || m_axi.arlen !== 8'd3 ||
                    m_axi.arsize !== 3'd3 || m_axi.arburst !== 2'b01) stable = 1'b0;
            end else if (nv > 0) break;
        end
        chk("ar_valid_cycles", 64'(nv), 3);
        chk("ar_fields_stable", 64'(stable), 1);
        @(posedge clk); #1;
        drain();
        ar_lat = 0;

        // Write, WREADY one cycle ahead of AWREADY
        w_lat = 1; aw_lat = 2; tick();
        send_req(1'b1, 32'h8000_0010, 3'd3, 8'd0, 64'h1122_3344_5566_7788, 8'h0F);
        wdrop = -1; adrop = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("aw_addr", 64'(m_axi.awaddr), 64'h8000_0010);
                chk("aw_len", 64'(m_axi.awlen), 0);
                chk("aw_size", 64'(m_axi.awsize), 3);
                chk("aw_burst", 64'(m_axi.awburst), 1);
                chk("w_data", m_axi.wdata, 64'h1122_3344_5566_7788);
                chk("w_strb", 64'(m_axi.wstrb), 64'h0F);
                chk("w_last", 64'(m_axi.wlast), 1);
            end
            if (!m_axi.wvalid && wdrop < 0) wdrop = c;
            if (!m_axi.awvalid && adrop < 0) adrop = c;
        end
        chk("w_drop_cycle", 64'(wdrop), 2);
        chk("aw_drop_cycle", 64'(adrop), 3);
        @(posedge clk); #1;
        drain();
        w_lat = 0; aw_lat = 0; tick();

        // Read len 1 with resp_ready toggling
        r0 = n_resp;
        rr_toggle = 1'b1;
        send_req(1'b0, 32'h0000_0040, 3'd3, 8'd1, 64'd0, 8'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_axi.rvalid) chk("rready_mirror", 64'(m_axi.rready), 64'(resp_ready));
            @(posedge clk); #1;
            if (sb.size() == 0) break;
        end
        rr_toggle = 1'b0; resp_ready = 1'b1;
        drain();
        chk("toggle_beats", 64'(n_resp - r0), 2);

        // Reset in the middle of a read burst
        send_req(1'b0, 32'h0000_0100, 3'd3, 8'd3, 64'd0, 8'd0);
        n0 = 0;
        while (sb.size() > 3 && n0 < 50) begin tick(); n0++; end
        chk("mid_rst_after_beat1", 64'(sb.size()), 3);
        rst = 1'b1; sb.delete();
        tick();
        @(negedge clk);
        chk("mid_rst_rready", 64'(m_axi.rready), 0);
        chk("mid_rst_req_ready", 64'(req_ready), 0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_req_ready", 64'(req_ready), 1);
        @(posedge clk); #1;

        // Error response: SLVERR on B, then an OKAY read
        bresp_cfg = 2'b10; tick();
        send_req(1'b1, 32'h0000_0200, 3'd3, 8'd0, 64'hDEAD_BEEF, 8'hFF);
        drain(); tick();
        @(negedge clk);
        chk("err_after_bresp", 64'(resp_err), 64'(ERR_EN));
        bresp_cfg = 2'b00;
        @(posedge clk); #1;
        send_req(1'b0, 32'h0000_0300, 3'd3, 8'd0, 64'd0, 8'd0);
        drain(); tick();
        @(negedge clk);
        chk("err_sticky", 64'(resp_err), 64'(ERR_EN));
        @(posedge clk); #1; rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(resp_err), 0);
        @(posedge clk); #1;

        // Back-to-back write then read with all readies high
        send_req(1'b1, 32'h0000_0400, 3'd3, 8'd0, 64'h55, 8'h01);
        send_req(1'b0, 32'h0000_0500, 3'd3, 8'd0, 64'd0, 8'd0);
        drain();
        chk("b_to_ar_gap", 64'(ar_cyc - b_cyc), 2);

        repeat (4) tick();
        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
